tick_meter: RTL

Measures the period and high time of a slow, asynchronous square wave, such as a divided tick clock or an external pulse, in cycles of the 50 MHz system clock. It is the receiving end of the slow-clock path: it synchronises the incoming wave, detects its edges, and reports one result per input period through a single-cycle valid strobe. It also flags a stalled or absent input through a timeout.

---
 rtl/tick_meter.sv | 118 +++++++++++
 1 files changed

// File: rtl/tick_meter.sv
// tick_meter: period / high-time meter for a slow asynchronous square wave.
// Build option TICK_METER_AVG_EN reports four-period averages.
module tick_meter #(
  parameter int               CNT_W   = 28,
  parameter logic [CNT_W-1:0] TIMEOUT = 28'd100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             edge_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - ONE;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_hold;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign cnt_inc = cnt + ONE;

`ifdef TICK_METER_AVG_EN
  logic [1:0]       avg_n;
  logic [CNT_W+1:0] sum_p, sum_h;
  logic [CNT_W+1:0] sum_p_nx, sum_h_nx;

  assign sum_p_nx = sum_p + {2'b00, cnt_inc};
  assign sum_h_nx = sum_h + {2'b00, high_hold};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      high_hold    <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      edge_tick    <= 1'b0;
      stalled      <= 1'b0;
`ifdef TICK_METER_AVG_EN
      avg_n        <= '0;
      sum_p        <= '0;
      sum_h        <= '0;
`endif
    end else begin
      s1           <= sig_in;
      s2           <= s1;
      s3           <= s2;
      edge_tick    <= rise;
      period_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            state   <= MEASURE;
            stalled <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt <= '0;
`ifdef TICK_METER_AVG_EN
            avg_n <= avg_n + 2'd1;
            if (avg_n == 2'd3) begin
              period       <= sum_p_nx[CNT_W+1:2];
              high_time    <= sum_h_nx[CNT_W+1:2];
              period_valid <= 1'b1;
              sum_p        <= '0;
              sum_h        <= '0;
            end else begin
              sum_p <= sum_p_nx;
              sum_h <= sum_h_nx;
            end
`else
            period       <= cnt_inc;
            high_time    <= high_hold;
            period_valid <= 1'b1;
`endif
          end else if (cnt == TO_LAST) begin
            // rise has priority above, so a late edge is never lost
            state   <= IDLE;
            stalled <= 1'b1;
            cnt     <= '0;
`ifdef TICK_METER_AVG_EN
            avg_n   <= '0;
            sum_p   <= '0;
            sum_h   <= '0;
`endif
          end else begin
            cnt <= cnt_inc;
            if (fall)
              high_hold <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
